// File: rtl/ins_fetch_seq_if.sv
// Fetch-side bundle: instruction-memory req/ack channel plus the decoded-field valid/ready channel.
// Carries the optional illegal flag when INS_FETCH_SEQ_ILLEGAL_CHECK_EN is defined.
interface ins_fetch_seq_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
`ifdef INS_FETCH_SEQ_ILLEGAL_CHECK_EN
    logic        illegal;

    modport master (
        output imem_req, imem_addr, out_valid, out_pc,
        output opcode, rd, funct3, rs1, rs2, funct7, illegal,
        input  imem_ack, imem_rdata, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_pc,
        input  opcode, rd, funct3, rs1, rs2, funct7, illegal,
        output imem_ack, imem_rdata, out_ready
    );
`else
    modport master (
        output imem_req, imem_addr, out_valid, out_pc,
        output opcode, rd, funct3, rs1, rs2, funct7,
        input  imem_ack, imem_rdata, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_pc,
        input  opcode, rd, funct3, rs1, rs2, funct7,
        output imem_ack, imem_rdata, out_ready
    );
`endif
endinterface

// File: rtl/ins_fetch_seq.sv
// RV32 instruction fetch sequencer: owns the PC, fetches over req/ack and presents decoded fields over valid/ready.
// Optional opcode legality check (halts after accept) is enabled by defining INS_FETCH_SEQ_ILLEGAL_CHECK_EN.
module ins_fetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  halt,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  busy,
    output logic                  err,
    ins_fetch_seq_if.master       bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [15:0] cnt_r, cnt_s;
    logic        err_r, err_s;
    logic [31:0] instr_r;
    logic [31:0] out_pc_r;
    logic        load_s;
    logic        stop_s;
    logic [31:0] redir_pc_s;

`ifdef INS_FETCH_SEQ_ILLEGAL_CHECK_EN
    logic        illegal_r;

    function automatic logic opcode_illegal(input logic [6:0] op);
        logic bad;
        case (op)
            7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
            7'h6F, 7'h67, 7'h37, 7'h17, 7'h73: bad = 1'b0;
            default:                           bad = 1'b1;
        endcase
        return bad;
    endfunction
`endif

    // Redirect targets are always word aligned.
    assign redir_pc_s = redirect_pc & 32'hFFFF_FFFC;

`ifdef INS_FETCH_SEQ_ILLEGAL_CHECK_EN
    assign stop_s = halt | illegal_r;
`else
    assign stop_s = halt;
`endif

    // Next-state, PC, timeout counter and error flag; redirect outranks ack and accept.
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        cnt_s   = cnt_r;
        err_s   = err_r;
        load_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (redirect_valid) begin
                    pc_s = redir_pc_s;
                end else begin
                    pc_s = pc_r;
                end
                if (start) begin
                    state_s = ST_REQ;
                    err_s   = 1'b0;
                    cnt_s   = 16'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (redirect_valid) begin
                    pc_s    = redir_pc_s;
                    cnt_s   = 16'd0;
                    state_s = ST_REQ;
                end else if (bus.imem_ack) begin
                    load_s  = 1'b1;
                    cnt_s   = 16'd0;
                    state_s = ST_OUT;
                end else if (cnt_r == CNT_LAST) begin
                    err_s   = 1'b1;
                    cnt_s   = 16'd0;
                    state_s = ST_IDLE;
                end else begin
                    cnt_s   = cnt_r + 16'd1;
                end
            end
            ST_OUT: begin
                if (redirect_valid) begin
                    pc_s    = redir_pc_s;
                    cnt_s   = 16'd0;
                    state_s = ST_REQ;
                end else if (bus.out_ready) begin
                    pc_s    = pc_r + 32'd4;
                    state_s = stop_s ? ST_IDLE : ST_REQ;
                end else begin
                    state_s = ST_OUT;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 16'd0;
            end
        endcase
    end

    // Control state, PC, counter and sticky error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            pc_r    <= RESET_PC;
            cnt_r   <= 16'd0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            cnt_r   <= cnt_s;
            err_r   <= err_s;
        end
    end

    // Instruction buffer and its PC, loaded only by an undisturbed ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_r  <= 32'd0;
            out_pc_r <= 32'd0;
        end else if (load_s) begin
            instr_r  <= bus.imem_rdata;
            out_pc_r <= pc_r;
        end else begin
            instr_r  <= instr_r;
            out_pc_r <= out_pc_r;
        end
    end

`ifdef INS_FETCH_SEQ_ILLEGAL_CHECK_EN
    // Legality flag travels with the buffered word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegal_r <= 1'b0;
        end else if (load_s) begin
            illegal_r <= opcode_illegal(bus.imem_rdata[6:0]);
        end else begin
            illegal_r <= illegal_r;
        end
    end

    assign bus.illegal = illegal_r;
`endif

    assign bus.imem_req  = (state_r == ST_REQ);
    assign bus.imem_addr = pc_r;
    assign bus.out_valid = (state_r == ST_OUT);
    assign bus.out_pc    = out_pc_r;
    assign bus.opcode    = instr_r[6:0];
    assign bus.rd        = instr_r[11:7];
    assign bus.funct3    = instr_r[14:12];
    assign bus.rs1       = instr_r[19:15];
    assign bus.rs2       = instr_r[24:20];
    assign bus.funct7    = instr_r[31:25];
    assign busy          = (state_r != ST_IDLE);
    assign err           = err_r;

endmodule

// File: tb/tb_ins_fetch_seq.sv
// Directed self-checking bench for ins_fetch_seq; inputs driven and outputs sampled on the falling edge.
module tb_ins_fetch_seq;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        halt;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;
    logic        err;
    int          n_checks;
    int          n_errors;
    int          req_cycles;

    ins_fetch_seq_if fif ();

    ins_fetch_seq #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (16)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy),
        .err            (err),
        .bus            (fif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n = 1'b1;
        start = 1'b0;
        halt = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        fif.imem_ack = 1'b0;
        fif.imem_rdata = 32'd0;
        fif.out_ready = 1'b0;
        #1 reset_n = 1'b0;
        tick();
        tick();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_req", 32'(fif.imem_req), 32'd0);
        check_eq("rst_valid", 32'(fif.out_valid), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_opcode", 32'(fif.opcode), 32'd0);
        check_eq("rst_outpc", fif.out_pc, 32'd0);
        reset_n = 1'b1;
        tick();

        // Test 1: first fetch with one-cycle ack
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("t1_req", 32'(fif.imem_req), 32'd1);
        check_eq("t1_addr0", fif.imem_addr, 32'h0000_0000);
        fif.imem_ack = 1'b1;
        fif.imem_rdata = 32'h00A3_02B3;
        tick();
        fif.imem_ack = 1'b0;
        check_eq("t1_valid", 32'(fif.out_valid), 32'd1);
        check_eq("t1_opcode", 32'(fif.opcode), 32'h33);
        check_eq("t1_rd", 32'(fif.rd), 32'd5);
        check_eq("t1_funct3", 32'(fif.funct3), 32'd0);
        check_eq("t1_rs1", 32'(fif.rs1), 32'd6);
        check_eq("t1_rs2", 32'(fif.rs2), 32'd10);
        check_eq("t1_funct7", 32'(fif.funct7), 32'd0);
        check_eq("t1_outpc", fif.out_pc, 32'h0000_0000);

        // Test 2: backpressure holds the presented instruction
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("t2_valid_hold", 32'(fif.out_valid), 32'd1);
            check_eq("t2_req_low", 32'(fif.imem_req), 32'd0);
            check_eq("t2_outpc_hold", fif.out_pc, 32'h0000_0000);
            check_eq("t2_opcode_hold", 32'(fif.opcode), 32'h33);
            check_eq("t2_rd_hold", 32'(fif.rd), 32'd5);
        end
        fif.out_ready = 1'b1;
        tick();
        fif.out_ready = 1'b0;
        check_eq("t2_valid_drop", 32'(fif.out_valid), 32'd0);
        check_eq("t2_req", 32'(fif.imem_req), 32'd1);
        check_eq("t2_addr4", fif.imem_addr, 32'h0000_0004);
        fif.imem_ack = 1'b1;
        fif.imem_rdata = 32'h0041_0113;
        tick();
        fif.imem_ack = 1'b0;
        check_eq("t2_opcode2", 32'(fif.opcode), 32'h13);
        check_eq("t2_rd2", 32'(fif.rd), 32'd2);
        check_eq("t2_rs1_2", 32'(fif.rs1), 32'd2);
        check_eq("t2_rs2_2", 32'(fif.rs2), 32'd4);
        check_eq("t2_outpc2", fif.out_pc, 32'h0000_0004);
        fif.out_ready = 1'b1;
        tick();
        fif.out_ready = 1'b0;

        // Test 3: redirect coincident with ack drops the word
        check_eq("t3_addr8", fif.imem_addr, 32'h0000_0008);
        fif.imem_ack = 1'b1;
        fif.imem_rdata = 32'h0000_0013;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        fif.imem_ack = 1'b0;
        redirect_valid = 1'b0;
        check_eq("t3_no_valid", 32'(fif.out_valid), 32'd0);
        check_eq("t3_req", 32'(fif.imem_req), 32'd1);
        check_eq("t3_addr_redir", fif.imem_addr, 32'h0000_0100);
        check_eq("t3_outpc_kept", fif.out_pc, 32'h0000_0004);
        fif.imem_ack = 1'b1;
        tick();
        fif.imem_ack = 1'b0;
        check_eq("t3_valid", 32'(fif.out_valid), 32'd1);
        check_eq("t3_outpc", fif.out_pc, 32'h0000_0100);
        fif.out_ready = 1'b1;
        halt = 1'b1;
        tick();
        fif.out_ready = 1'b0;
        halt = 1'b0;
        check_eq("t3_halt_idle", 32'(busy), 32'd0);
        check_eq("t3_halt_noreq", 32'(fif.imem_req), 32'd0);

        // Test 4: no ack -> timeout after 16 request cycles
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("t4_addr", fif.imem_addr, 32'h0000_0104);
        req_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (fif.imem_req) begin
                req_cycles++;
                tick();
            end
        end
        check_eq("t4_req_cycles", 32'(req_cycles), 32'd16);
        check_eq("t4_err", 32'(err), 32'd1);
        check_eq("t4_busy", 32'(busy), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("t4_err_clr", 32'(err), 32'd0);
        check_eq("t4_restart_req", 32'(fif.imem_req), 32'd1);

        // Test 5: wrap at top of address space with halt
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        check_eq("t5_addr_top", fif.imem_addr, 32'hFFFF_FFFC);
        fif.imem_ack = 1'b1;
        fif.imem_rdata = 32'h0000_0013;
        tick();
        fif.imem_ack = 1'b0;
        check_eq("t5_outpc_top", fif.out_pc, 32'hFFFF_FFFC);
        fif.out_ready = 1'b1;
        halt = 1'b1;
        tick();
        fif.out_ready = 1'b0;
        halt = 1'b0;
        check_eq("t5_idle", 32'(busy), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("t5_wrap_addr", fif.imem_addr, 32'h0000_0000);
        halt = 1'b1;
        tick();
        check_eq("t5_halt_in_req", 32'(fif.imem_req), 32'd1);
        halt = 1'b0;
        fif.imem_ack = 1'b1;
        fif.imem_rdata = 32'h00A3_02B3;
        tick();
        fif.imem_ack = 1'b0;
        fif.out_ready = 1'b1;
        tick();
        fif.out_ready = 1'b0;
        check_eq("t5_step_addr", fif.imem_addr, 32'h0000_0004);
        #2 reset_n = 1'b0;
        #1;
        check_eq("t5_rst_req", 32'(fif.imem_req), 32'd0);
        check_eq("t5_rst_pc", fif.imem_addr, 32'h0000_0000);
        check_eq("t5_rst_opcode", 32'(fif.opcode), 32'd0);
        check_eq("t5_rst_busy", 32'(busy), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Test 6: unknown opcode 7'h7F
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("t6_addr0", fif.imem_addr, 32'h0000_0000);
        fif.imem_ack = 1'b1;
        fif.imem_rdata = 32'h0000_007F;
        tick();
        fif.imem_ack = 1'b0;
        check_eq("t6_valid", 32'(fif.out_valid), 32'd1);
        check_eq("t6_opcode", 32'(fif.opcode), 32'h7F);
`ifdef INS_FETCH_SEQ_ILLEGAL_CHECK_EN
        check_eq("t6_illegal", 32'(fif.illegal), 32'd1);
`endif
        fif.out_ready = 1'b1;
        tick();
        fif.out_ready = 1'b0;
`ifdef INS_FETCH_SEQ_ILLEGAL_CHECK_EN
        check_eq("t6_halt_busy", 32'(busy), 32'd0);
        check_eq("t6_halt_req", 32'(fif.imem_req), 32'd0);
`else
        check_eq("t6_step_busy", 32'(busy), 32'd1);
        check_eq("t6_step_addr", fif.imem_addr, 32'h0000_0004);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ins_fetch_seq.md
Name: ins_fetch_seq

Overview:
- Sequences fetch of 32-bit RV32 instructions from instruction memory over a req/ack handshake.
- Splits each fetched word into opcode/rd/funct3/rs1/rs2/funct7 and presents it downstream over valid/ready.
- Owns the PC: sequential +4 stepping, redirect from the execute stage, and halt/start control.
- Sits between instruction memory and the decode/control stage of the lab CPU.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, cycles allowed from request start to imem_ack before an error is raised; legal range 2..65535.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  level; begins fetching from the current PC when in IDLE.
- halt  in  1  level; stop after the current instruction is consumed.
- imem_req  out  1  memory request; held until imem_ack.
- imem_addr  out  32  fetch address, always equal to pc while imem_req=1.
- imem_ack  in  1  memory accepted the request; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- redirect_valid  in  1  one-cycle pulse; load a new PC.
- redirect_pc  in  32  target PC, sampled when redirect_valid=1.
- out_valid  out  1  decoded fields are valid.
- out_ready  in  1  downstream accepts the fields.
- out_pc  out  32  PC of the presented instruction.
- opcode  out  7  instr[6:0].
- rd  out  5  instr[11:7].
- funct3  out  3  instr[14:12].
- rs1  out  5  instr[19:15].
- rs2  out  5  instr[24:20].
- funct7  out  7  instr[31:25].
- busy  out  1  1 when state != IDLE.
- err  out  1  sticky fetch-timeout flag.

Behaviour:
Reset (async, reset_n=0):
- State is IDLE and pc=RESET_PC.
- Instruction buffer is 0, so every field output is 0.
- imem_req, out_valid, busy and err are 0; the timeout counter is 0.

Field outputs:
- Driven combinationally from the registered 32-bit instruction buffer.
- out_pc is registered; it is loaded together with the buffer.

State machine:
- IDLE: start=1 -> REQ and err is cleared. A redirect_valid received in IDLE still loads pc.
- REQ: imem_req=1 and imem_addr=pc.
  - imem_ack=1 -> buffer<=imem_rdata, out_pc<=pc, state -> OUT; the counter resets.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without ack, err<=1 and state -> IDLE.
- OUT: out_valid=1.
  - out_ready=1 -> pc<=pc+4.
  - After acceptance, go to IDLE if halt=1, else to REQ.
  - Fields and out_pc stay stable while out_valid=1 and out_ready=0.

Latency and throughput:
- Minimum latency is 1 cycle from imem_req assertion to out_valid: ack in the first REQ cycle gives out_valid in the next cycle.
- Best-case throughput is one instruction per 2 cycles.

Arithmetic:
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- redirect_pc[1:0] is forced to 0.

Redirect (highest priority in REQ and OUT):
- pc<=redirect_pc and any buffered instruction is discarded; out_valid drops the next cycle.
- State -> REQ and the counter is cleared.
- Redirect with imem_ack in the same cycle: rdata is discarded and the next request uses redirect_pc.
- Redirect with out_valid&out_ready in the same cycle: the handshake completes, but pc takes redirect_pc, not pc+4.

Halt:
- Sampled only at OUT acceptance.
- halt=1 in REQ does not abort the outstanding request.

start while busy: ignored.

Reset mid-operation:
- Everything returns immediately to reset values.
- An outstanding memory request is abandoned; imem_req drops asynchronously.

Optional Feature:
- Macro: INS_FETCH_SEQ_ILLEGAL_CHECK_EN.
- With the macro defined:
  - Adds an output illegal (1 bit, registered with the buffer, reset 0).
  - illegal=1 when the latched opcode is not one of 7'h33, 13, 03, 23, 63, 6F, 67, 37, 17, 73.
  - illegal=1 causes halt-after-accept behaviour, regardless of the halt input.
- Without the macro:
  - No illegal port.
  - Opcode is never checked.

Test Plan:
1. Reset with RESET_PC=0; pulse start; memory acks in 1 cycle with words 32'h00A3_02B3, 32'h0041_0113 -> imem_addr 0 then 4. First word yields opcode=7'h33, rd=5, funct3=0, rs1=6, rs2=10, funct7=0.
2. Hold out_ready=0 for 5 cycles in OUT -> out_valid stays 1 with fields and out_pc constant, imem_req stays 0, pc unchanged. Release out_ready -> next imem_addr=pc+4.
3. Pulse redirect_valid with redirect_pc=32'h0000_0103 in the same cycle as imem_ack -> rdata dropped, next imem_addr=32'h0000_0100, out_valid does not assert for the dropped word.
4. TIMEOUT=16, memory never acks -> imem_req high for 16 cycles, then err=1, state IDLE, busy=0. A later start clears err.
5. Fetch at pc=32'hFFFF_FFFC with halt=1 at acceptance -> pc becomes 0, FSM goes to IDLE, busy=0. Deassert reset_n mid-REQ -> imem_req=0 immediately and pc=RESET_PC.
6. With INS_FETCH_SEQ_ILLEGAL_CHECK_EN defined, fetch 32'h0000_007F -> illegal=1 with out_valid, FSM goes to IDLE after acceptance. Without the macro the same word gives normal stepping.
